mcd_wram_arbiter: RTL and testbench

//  Single-port scheduler for the 2M word RAM while it is mapped to the sub side (wram_mode=0, wram_for_sub=1).

---
 rtl/mcd_wram_arbiter_if.sv | 37 +++
 rtl/mcd_wram_arbiter.sv | 148 ++++++++++++++
 tb/tb_mcd_wram_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcd_wram_arbiter_if.sv
// Requester and RAM-side signal bundle for the sub-side word RAM arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface mcd_wram_arbiter_if;
   logic        wram_mode;
   logic        wram_for_sub;
   logic        s_req, d_req, a_req;
   logic [16:0] s_addr, d_addr, a_addr;
   logic        s_we, d_we, a_we;
   logic [1:0]  s_be;
   logic [15:0] s_din, d_din, a_din;
   logic        s_ack, d_ack, a_ack;
   logic [15:0] rdata;
   logic [16:0] ram_addr;
   logic [15:0] ram_din;
   logic [1:0]  ram_we;
   logic        ram_oe;
   logic [15:0] ram_dout;
   logic        busy;

   modport slave (
      input  wram_mode, wram_for_sub,
      input  s_req, d_req, a_req, s_addr, d_addr, a_addr,
      input  s_we, d_we, a_we, s_be, s_din, d_din, a_din,
      output s_ack, d_ack, a_ack, rdata,
      output ram_addr, ram_din, ram_we, ram_oe, busy,
      input  ram_dout
   );

   modport master (
      output wram_mode, wram_for_sub,
      output s_req, d_req, a_req, s_addr, d_addr, a_addr,
      output s_we, d_we, a_we, s_be, s_din, d_din, a_din,
      input  s_ack, d_ack, a_ack, rdata,
      input  ram_addr, ram_din, ram_we, ram_oe, busy,
      output ram_dout
   );
endinterface

// File: rtl/mcd_wram_arbiter.sv
// Single-port scheduler sharing the 2M word RAM between sub-CPU, CDC DMA and rotation ASIC.
// One word access at a time: grant, RAM_LAT access cycles, one-cycle ack.
module mcd_wram_arbiter #(
   parameter int RAM_LAT    = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_asic,
   input  logic              rst,
   mcd_wram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_ACK} state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_S, REQ_D, REQ_A} req_t;

   state_t      state_q, state_d;
   req_t        owner_q, owner_d, win;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  starve_q, starve_d;
   logic [16:0] ram_addr_q, ram_addr_d;
   logic [15:0] ram_din_q, ram_din_d;
   logic [15:0] rdata_q, rdata_d;
   logic [1:0]  ram_we_q, ram_we_d;
   logic        ram_oe_q, ram_oe_d;
   logic        busy_q, busy_d;
   logic [2:0]  ack_q, ack_d;   // {s, d, a}
   logic        open;

   assign open = !bus.wram_mode && bus.wram_for_sub;

   // A starved ASIC jumps the queue; otherwise fixed S > D > A.
   always_comb begin
      win = REQ_NONE;
      if (bus.a_req && (starve_q == 4'(STARVE_MAX))) win = REQ_A;
      else if (bus.s_req)                            win = REQ_S;
      else if (bus.d_req)                            win = REQ_D;
      else if (bus.a_req)                            win = REQ_A;
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lat_cnt_d  = lat_cnt_q;
      starve_d   = starve_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      rdata_d    = rdata_q;
      ram_we_d   = ram_we_q;
      ram_oe_d   = ram_oe_q;
      busy_d     = busy_q;
      ack_d      = 3'b000;

      case (state_q)
         ST_IDLE: begin
            if (open && (win != REQ_NONE)) begin
               owner_d   = win;
               lat_cnt_d = 3'(RAM_LAT - 1);
               busy_d    = 1'b1;
               state_d   = ST_ACC;
               case (win)
                  REQ_S: begin
                     ram_addr_d = bus.s_addr;
                     ram_din_d  = bus.s_din;
                     ram_oe_d   = !bus.s_we;
                     ram_we_d   = bus.s_we ? bus.s_be : 2'b00;
                  end
                  REQ_D: begin
                     ram_addr_d = bus.d_addr;
                     ram_din_d  = bus.d_din;
                     ram_oe_d   = !bus.d_we;
                     ram_we_d   = bus.d_we ? 2'b11 : 2'b00;
                  end
                  default: begin
                     ram_addr_d = bus.a_addr;
                     ram_din_d  = bus.a_din;
                     ram_oe_d   = !bus.a_we;
                     ram_we_d   = bus.a_we ? 2'b11 : 2'b00;
                  end
               endcase
               if (bus.a_req) begin
                  if (win == REQ_A)          starve_d = 4'd0;
                  else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
               end
            end
         end
         ST_ACC: begin
            if (lat_cnt_q == 3'd0) begin
               if (ram_oe_q) rdata_d = bus.ram_dout;
               ram_oe_d = 1'b0;
               ram_we_d = 2'b00;
               busy_d   = 1'b0;
               state_d  = ST_ACK;
               case (owner_q)
                  REQ_S:   ack_d = 3'b100;
                  REQ_D:   ack_d = 3'b010;
                  REQ_A:   ack_d = 3'b001;
                  default: ack_d = 3'b000;
               endcase
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         ST_ACK: begin
            owner_d = REQ_NONE;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!bus.a_req) starve_d = 4'd0;
   end

   always_ff @(posedge clk_asic) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= REQ_NONE;
         lat_cnt_q  <= 3'd0;
         starve_q   <= 4'd0;
         ram_addr_q <= 17'd0;
         ram_din_q  <= 16'd0;
         rdata_q    <= 16'd0;
         ram_we_q   <= 2'b00;
         ram_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 3'b000;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lat_cnt_q  <= lat_cnt_d;
         starve_q   <= starve_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         rdata_q    <= rdata_d;
         ram_we_q   <= ram_we_d;
         ram_oe_q   <= ram_oe_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
      end
   end

   assign bus.s_ack    = ack_q[2];
   assign bus.d_ack    = ack_q[1];
   assign bus.a_ack    = ack_q[0];
   assign bus.rdata    = rdata_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.ram_oe   = ram_oe_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mcd_wram_arbiter.sv
// Bench for mcd_wram_arbiter: directed vector table, corner sequences, and a
// randomized run against a cycle-timeline reference model.
module tb_mcd_wram_arbiter;
   localparam int RAM_LAT    = 3;
   localparam int STARVE_MAX = 4;

   logic clk_asic = 1'b0;
   logic rst      = 1'b1;
   always #5 clk_asic = ~clk_asic;

   mcd_wram_arbiter_if bus ();

   mcd_wram_arbiter #(.RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_asic (clk_asic),
      .rst      (rst),
      .bus      (bus)
   );

   // RAM stand-in: unwritten words read as a fixed address pattern.
   bit [15:0]   dev_mem [0:131071];
   bit          dev_vld [0:131071];
   logic [15:0] dev_cur;

   function automatic logic [15:0] init_val(input logic [16:0] a);
      return a[15:0] ^ 16'h5a5a;
   endfunction

   function automatic logic [15:0] dev_rd(input logic [16:0] a);
      return dev_vld[a] ? dev_mem[a] : init_val(a);
   endfunction

   assign dev_cur      = dev_rd(bus.ram_addr);
   assign bus.ram_dout = bus.ram_oe ? dev_cur : 16'h0000;

   always @(posedge clk_asic) begin
      if (|bus.ram_we) begin
         dev_mem[bus.ram_addr] <= {bus.ram_we[1] ? bus.ram_din[15:8] : dev_cur[15:8],
                                   bus.ram_we[0] ? bus.ram_din[7:0]  : dev_cur[7:0]};
         dev_vld[bus.ram_addr] <= 1'b1;
      end
   end

   logic [2:0] acks;
   assign acks = {bus.s_ack, bus.d_ack, bus.a_ack};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int who_of(input logic [2:0] a);
      case (a)
         3'b100:  return 0;
         3'b010:  return 1;
         3'b001:  return 2;
         default: return -1;
      endcase
   endfunction

   task automatic req_set(input int who, input logic v, input logic we, input logic [1:0] be,
                          input logic [16:0] addr, input logic [15:0] din);
      case (who)
         0: begin bus.s_req = v; bus.s_we = we; bus.s_be = be; bus.s_addr = addr; bus.s_din = din; end
         1: begin bus.d_req = v; bus.d_we = we; bus.d_addr = addr; bus.d_din = din; end
         default: begin bus.a_req = v; bus.a_we = we; bus.a_addr = addr; bus.a_din = din; end
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk_asic);
      rst = 1'b1;
      bus.wram_mode = 1'b0;
      bus.wram_for_sub = 1'b1;
      for (int i = 0; i < 3; i++) req_set(i, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      @(negedge clk_asic);
      rst = 1'b0;
   endtask

   typedef struct {
      int          who;
      logic        we;
      logic [1:0]  be;
      logic [16:0] addr;
      logic [15:0] din;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs [10];

   // One isolated access: latency, strobe duration, read data / memory effect.
   task automatic run_vec(input int idx, input vec_t v);
      int n, act_cnt, lat;
      logic [1:0] strobe;
      strobe = (v.who == 0) ? v.be : 2'b11;
      act_cnt = 0;
      lat = 99;
      req_set(v.who, 1'b1, v.we, v.be, v.addr, v.din);
      for (n = 1; n <= 20; n++) begin
         @(negedge clk_asic);
         if (v.we ? (bus.ram_we == strobe) : (bus.ram_oe && bus.ram_we == 2'b00)) act_cnt++;
         if (acks != 3'b000) begin
            lat = n;
            chk($sformatf("vec%0d_ackwho", idx), 32'(who_of(acks)), 32'(v.who));
            if (!v.we) chk($sformatf("vec%0d_rdata", idx), 32'(bus.rdata), 32'(v.exp_word));
            break;
         end
      end
      req_set(v.who, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(RAM_LAT + 1));
      chk($sformatf("vec%0d_strobe_cycles", idx), 32'(act_cnt), 32'(RAM_LAT));
      @(negedge clk_asic);
      if (v.we) chk($sformatf("vec%0d_memword", idx), 32'(dev_rd(v.addr)), 32'(v.exp_word));
      $display("vec %0d who=%0d we=%0d addr=%05h lat=%0d", idx, v.who, v.we, v.addr, lat);
   endtask

   // Reference model state for the randomized run.
   logic [15:0] mdl_mem [logic [16:0]];
   logic        r_req [3];
   logic        r_we  [3];
   logic [1:0]  r_be  [3];
   logic [16:0] r_addr[3];
   logic [15:0] r_din [3];

   function automatic logic [15:0] mdl_rd(input logic [16:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
   endfunction

   initial begin
      int t[10];
      int w[10];
      int cnt;
      int exp_seq[10];
      logic seen;
      int lat;
      logic multi;
      logic [15:0] exp3[3];

      vecs[0] = '{2, 1'b1, 2'b11, 17'h00100, 16'h1234, 16'h1234};
      vecs[1] = '{2, 1'b0, 2'b11, 17'h00100, 16'h0000, 16'h1234};
      vecs[2] = '{0, 1'b1, 2'b10, 17'h00200, 16'hABCD, 16'hAB5A};
      vecs[3] = '{0, 1'b0, 2'b01, 17'h00200, 16'h0000, 16'hAB5A};
      vecs[4] = '{1, 1'b1, 2'b11, 17'h00300, 16'h5555, 16'h5555};
      vecs[5] = '{1, 1'b0, 2'b11, 17'h00300, 16'h0000, 16'h5555};
      vecs[6] = '{0, 1'b1, 2'b01, 17'h00000, 16'h00C3, 16'h5AC3};
      vecs[7] = '{2, 1'b1, 2'b11, 17'h1FFFF, 16'hFFFF, 16'hFFFF};
      vecs[8] = '{2, 1'b0, 2'b11, 17'h1FFFF, 16'h0000, 16'hFFFF};
      vecs[9] = '{0, 1'b0, 2'b11, 17'h00010, 16'h0000, 16'h5A4A};

      bus.wram_mode = 1'b0;
      bus.wram_for_sub = 1'b1;
      for (int i = 0; i < 3; i++) req_set(i, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      @(negedge clk_asic);
      @(negedge clk_asic);
      chk("rst_acks", 32'(acks), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_oe", 32'(bus.ram_oe), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_din", 32'(bus.ram_din), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      $display("reset state checked");
      rst = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Three simultaneous requests: S, D, A, one access every RAM_LAT+2.
      do_reset();
      exp3[0] = 16'h1234; exp3[1] = 16'hAB5A; exp3[2] = 16'h5555;
      req_set(0, 1'b1, 1'b0, 2'b11, 17'h00100, 16'd0);
      req_set(1, 1'b1, 1'b0, 2'b11, 17'h00200, 16'd0);
      req_set(2, 1'b1, 1'b0, 2'b11, 17'h00300, 16'd0);
      cnt = 0; multi = 1'b0;
      for (int i = 0; i < 10; i++) begin t[i] = -100; w[i] = -1; end
      for (int n = 1; n <= 40 && cnt < 3; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000) begin
            if (!$onehot(acks)) multi = 1'b1;
            w[cnt] = who_of(acks);
            t[cnt] = n;
            if (w[cnt] >= 0) begin
               chk($sformatf("simul_rdata%0d", cnt), 32'(bus.rdata), 32'(exp3[w[cnt]]));
               req_set(w[cnt], 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
            end
            $display("simul ack %0d who=%0d cycle=%0d", cnt, w[cnt], n);
            cnt++;
         end
      end
      for (int i = 0; i < 3; i++) chk($sformatf("simul_order%0d", i), 32'(w[i]), 32'(i));
      chk("simul_first_lat", 32'(t[0]), 32'(RAM_LAT + 1));
      chk("simul_gap1", 32'(t[1] - t[0]), 32'(RAM_LAT + 2));
      chk("simul_gap2", 32'(t[2] - t[1]), 32'(RAM_LAT + 2));
      chk("simul_onehot", 32'(multi), 32'd0);

      // S and A hammering: A promoted after STARVE_MAX lost arbitrations.
      do_reset();
      req_set(0, 1'b1, 1'b0, 2'b11, 17'h00010, 16'd0);
      req_set(2, 1'b1, 1'b0, 2'b11, 17'h00011, 16'd0);
      for (int i = 0; i < 10; i++) begin
         w[i] = -1;
         exp_seq[i] = ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 2 : 0;
      end
      cnt = 0;
      for (int n = 1; n <= 100 && cnt < 10; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000) begin
            w[cnt] = who_of(acks);
            $display("starve ack %0d who=%0d", cnt, w[cnt]);
            cnt++;
         end
      end
      req_set(0, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      req_set(2, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), 32'(w[i]), 32'(exp_seq[i]));

      // Ownership loss during a D write; pending A waits until the RAM is open again.
      do_reset();
      req_set(1, 1'b1, 1'b1, 2'b11, 17'h00300, 16'h0F0F);
      req_set(2, 1'b1, 1'b0, 2'b11, 17'h00100, 16'd0);
      @(negedge clk_asic);
      @(negedge clk_asic);
      bus.wram_for_sub = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000) begin
            seen = 1'b1;
            chk("own_ack_is_d", 32'(acks), 32'b010);
         end
      end
      chk("own_d_acked", 32'(seen), 32'd1);
      req_set(1, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000 || bus.busy) seen = 1'b1;
      end
      chk("own_closed_nogrant", 32'(seen), 32'd0);
      bus.wram_mode = 1'b1;
      bus.wram_for_sub = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000 || bus.busy) seen = 1'b1;
      end
      chk("own_1m_nogrant", 32'(seen), 32'd0);
      bus.wram_mode = 1'b0;
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000) begin
            lat = n;
            chk("own_a_ack", 32'(acks), 32'b001);
            chk("own_a_rdata", 32'(bus.rdata), 32'h1234);
            break;
         end
      end
      req_set(2, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      chk("own_a_latency", 32'(lat), 32'(RAM_LAT + 1));
      $display("ownership sequence a latency=%0d", lat);

      // Reset during ACC: strobes drop, no ack, held request re-granted.
      do_reset();
      req_set(0, 1'b1, 1'b1, 2'b11, 17'h00500, 16'hBEEF);
      @(negedge clk_asic);
      @(negedge clk_asic);
      chk("rstacc_pre_we", 32'(bus.ram_we), 32'b11);
      chk("rstacc_pre_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk_asic);
      chk("rstacc_we", 32'(bus.ram_we), 32'd0);
      chk("rstacc_oe", 32'(bus.ram_oe), 32'd0);
      chk("rstacc_busy", 32'(bus.busy), 32'd0);
      chk("rstacc_noack", 32'(acks), 32'd0);
      rst = 1'b0;
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_asic);
         if (acks != 3'b000) begin
            lat = n;
            chk("rstacc_ack_s", 32'(acks), 32'b100);
            break;
         end
      end
      req_set(0, 1'b0, 1'b0, 2'b11, 17'd0, 16'd0);
      chk("rstacc_regrant_lat", 32'(lat), 32'(RAM_LAT + 1));
      $display("reset-in-access sequence regrant latency=%0d", lat);

      // Randomized traffic against the timeline model.
      do_reset();
      begin
         int starve, next_free, g_cyc, ack_cyc, g_who, grants, dut_acks;
         logic inflight, g_read, granted, open_m;
         logic [15:0] g_exp, old_w;
         logic [1:0] bemask;
         logic [2:0] exp_ack;
         starve = 0; next_free = 0; g_cyc = -100; ack_cyc = -100; g_who = 0;
         grants = 0; dut_acks = 0; inflight = 1'b0; g_read = 1'b0; g_exp = '0;
         for (int i = 0; i < 3; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_be[i] = 2'b11; r_addr[i] = '0; r_din[i] = '0;
         end
         for (int cyc = 0; cyc < 700; cyc++) begin
            exp_ack = 3'b000;
            if (inflight && cyc == ack_cyc) exp_ack = 3'b100 >> g_who;
            if (acks != 3'b000) dut_acks++;
            chk("rnd_ack", 32'(acks), 32'(exp_ack));
            chk("rnd_busy", 32'(bus.busy),
                32'(inflight && cyc > g_cyc && cyc <= g_cyc + RAM_LAT));
            if (exp_ack != 3'b000) begin
               if (g_read) chk("rnd_rdata", 32'(bus.rdata), 32'(g_exp));
               $display("rnd cyc=%0d ack who=%0d read=%0d data=%04h", cyc, g_who, g_read, bus.rdata);
               r_req[g_who] = 1'b0;
               inflight = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
               if (!r_req[i] && cyc < 600 && $urandom_range(0, 3) == 0) begin
                  r_req[i]  = 1'b1;
                  r_we[i]   = 1'($urandom_range(0, 1));
                  r_be[i]   = (i == 0) ? 2'($urandom_range(1, 3)) : 2'b11;
                  r_addr[i] = 17'h00400 + 17'($urandom_range(0, 7));
                  r_din[i]  = 16'($urandom);
               end
            end
            bus.wram_for_sub = (cyc >= 600) || ($urandom_range(0, 7) != 0);
            bus.wram_mode    = (cyc < 600) && ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 3; i++) req_set(i, r_req[i], r_we[i], r_be[i], r_addr[i], r_din[i]);
            open_m  = !bus.wram_mode && bus.wram_for_sub;
            granted = 1'b0;
            if (!inflight && cyc >= next_free && open_m && (r_req[0] || r_req[1] || r_req[2])) begin
               if (r_req[2] && starve == STARVE_MAX) g_who = 2;
               else if (r_req[0])                    g_who = 0;
               else if (r_req[1])                    g_who = 1;
               else                                  g_who = 2;
               granted   = 1'b1;
               grants++;
               inflight  = 1'b1;
               g_cyc     = cyc;
               ack_cyc   = cyc + RAM_LAT + 1;
               next_free = cyc + RAM_LAT + 2;
               g_read    = !r_we[g_who];
               old_w     = mdl_rd(r_addr[g_who]);
               if (g_read) begin
                  g_exp = old_w;
               end else begin
                  bemask = (g_who == 0) ? r_be[0] : 2'b11;
                  mdl_mem[r_addr[g_who]] = {bemask[1] ? r_din[g_who][15:8] : old_w[15:8],
                                            bemask[0] ? r_din[g_who][7:0]  : old_w[7:0]};
               end
            end
            if (!r_req[2])    starve = 0;
            else if (granted) starve = (g_who == 2) ? 0 : ((starve < 15) ? starve + 1 : 15);
            @(negedge clk_asic);
         end
         chk("rnd_all_served", 32'(inflight || r_req[0] || r_req[1] || r_req[2]), 32'd0);
         chk("rnd_ack_count", 32'(dut_acks), 32'(grants));
         $display("rnd grants=%0d dut_acks=%0d", grants, dut_acks);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
